// File: rtl/link_status_monitor.sv
// link_status_monitor: per-channel link FSMs, blink-coded LEDs, drop counters, pb debounce.
// Define LSM_DROP_IRQ_EN to add the sticky drop_irq output.
module link_status_monitor #(
  parameter int NUM_CH       = 2,
  parameter int NUM_LANES    = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SLOW_HALF    = 50_000_000,
  parameter int FAST_HALF    = 12_500_000,
  parameter int DROP_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             channel_up,
  input  logic [NUM_CH*NUM_LANES-1:0]   lane_up,
  input  logic [NUM_CH-1:0]             pll_lock,
  input  logic                          calib_done,
  input  logic                          pb_raw,
  output logic [NUM_CH-1:0]             led_link,
  output logic [NUM_CH-1:0]             led_lanes,
  output logic [NUM_CH-1:0]             led_pll,
  output logic                          led_calib,
  output logic [NUM_CH*DROP_W-1:0]      drop_cnt,
  output logic                          pb_pulse
`ifdef LSM_DROP_IRQ_EN
  ,
  output logic                          drop_irq
`endif
);

  localparam int LW = NUM_CH * NUM_LANES;
  localparam int IW = LW + 2 * NUM_CH + 2;
  localparam int SW = $clog2(SLOW_HALF + 1);
  localparam int FW = $clog2(FAST_HALF + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {
    DOWN,
    TRAIN,
    UP,
    LOST
  } state_t;

  logic [IW-1:0]     sync_q [SYNC_STAGES];
  logic [IW-1:0]     in_s;
  logic [LW-1:0]     lane_s;
  logic [NUM_CH-1:0] cu_s;
  logic [NUM_CH-1:0] pll_s;
  logic              calib_s;
  logic              pb_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {pb_raw, calib_done, pll_lock, channel_up, lane_up};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign in_s    = sync_q[SYNC_STAGES-1];
  assign lane_s  = in_s[LW-1:0];
  assign cu_s    = in_s[LW +: NUM_CH];
  assign pll_s   = in_s[LW+NUM_CH +: NUM_CH];
  assign calib_s = in_s[IW-2];
  assign pb_s    = in_s[IW-1];

  // Free-running blink phases
  logic [SW-1:0] slow_cnt;
  logic [FW-1:0] fast_cnt;
  logic          slow_ph;
  logic          fast_ph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slow_cnt <= '0;
      fast_cnt <= '0;
      slow_ph  <= 1'b0;
      fast_ph  <= 1'b0;
    end else begin
      if (slow_cnt == SW'(SLOW_HALF - 1)) begin
        slow_cnt <= '0;
        slow_ph  <= ~slow_ph;
      end else begin
        slow_cnt <= slow_cnt + 1'b1;
      end
      if (fast_cnt == FW'(FAST_HALF - 1)) begin
        fast_cnt <= '0;
        fast_ph  <= ~fast_ph;
      end else begin
        fast_cnt <= fast_cnt + 1'b1;
      end
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYC consecutive differing samples
  logic          db;
  logic [DW-1:0] db_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db       <= 1'b0;
      db_cnt   <= '0;
      pb_pulse <= 1'b0;
    end else begin
      pb_pulse <= 1'b0;
      if (pb_s == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
        db       <= pb_s;
        db_cnt   <= '0;
        pb_pulse <= pb_s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  state_t            state    [NUM_CH];
  state_t            state_nx [NUM_CH];
  logic [NUM_CH-1:0] drop;

  always_comb begin
    drop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      state_nx[c] = state[c];
      unique case (state[c])
        DOWN: begin
          if (cu_s[c]) state_nx[c] = UP;
          else if (pll_s[c]) state_nx[c] = TRAIN;
        end
        TRAIN: begin
          if (cu_s[c]) state_nx[c] = UP;
          else if (!pll_s[c]) state_nx[c] = DOWN;
        end
        UP: begin
          if (!cu_s[c]) begin
            state_nx[c] = LOST;
            drop[c]     = 1'b1;
          end
        end
        LOST: begin
          if (cu_s[c]) state_nx[c] = UP;
          else if (pb_pulse) state_nx[c] = DOWN;
        end
        default: state_nx[c] = DOWN;
      endcase
    end
  end

  logic [DROP_W-1:0] cnt [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state[c] <= DOWN;
        cnt[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state[c] <= state_nx[c];
        // A drop coinciding with the clear leaves a count of one
        if (pb_pulse) cnt[c] <= drop[c] ? DROP_W'(1) : '0;
        else if (drop[c] && cnt[c] != '1) cnt[c] <= cnt[c] + 1'b1;
      end
    end
  end

  logic [NUM_CH-1:0] lanes_ok;
  logic [NUM_CH-1:0] lanes_d;
  logic [NUM_CH-1:0] pll_d;

  always_comb begin
    lanes_ok = '0;
    for (int c = 0; c < NUM_CH; c++)
      lanes_ok[c] = &lane_s[c*NUM_LANES +: NUM_LANES];
  end

  // Extra stage keeps lane/pll LEDs aligned with the link LED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_d   <= '0;
      pll_d     <= '0;
      led_lanes <= '0;
      led_pll   <= '0;
      led_calib <= 1'b0;
      led_link  <= '0;
      drop_cnt  <= '0;
    end else begin
      lanes_d   <= lanes_ok;
      pll_d     <= pll_s;
      led_lanes <= lanes_d;
      led_pll   <= pll_d;
      led_calib <= calib_s;
      for (int c = 0; c < NUM_CH; c++) begin
        unique case (state[c])
          TRAIN:   led_link[c] <= slow_ph;
          UP:      led_link[c] <= 1'b1;
          LOST:    led_link[c] <= fast_ph;
          default: led_link[c] <= 1'b0;
        endcase
        drop_cnt[c*DROP_W +: DROP_W] <= cnt[c];
      end
    end
  end

`ifdef LSM_DROP_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_irq <= 1'b0;
    else if (|drop) drop_irq <= 1'b1;
    else if (pb_pulse) drop_irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_link_status_monitor.sv
// Scoreboard bench for link_status_monitor with small timing parameters.
module tb_link_status_monitor;

  localparam int NUM_CH    = 2;
  localparam int NUM_LANES = 4;
  localparam int DROP_W    = 4;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [NUM_CH-1:0]           channel_up = '0;
  logic [NUM_CH*NUM_LANES-1:0] lane_up = '0;
  logic [NUM_CH-1:0]           pll_lock = '0;
  logic                        calib_done = 1'b0;
  logic                        pb_raw = 1'b0;
  logic [NUM_CH-1:0]           led_link;
  logic [NUM_CH-1:0]           led_lanes;
  logic [NUM_CH-1:0]           led_pll;
  logic                        led_calib;
  logic [NUM_CH*DROP_W-1:0]    drop_cnt;
  logic                        pb_pulse;
`ifdef LSM_DROP_IRQ_EN
  logic                        drop_irq;
`endif

  link_status_monitor #(
    .NUM_CH(NUM_CH), .NUM_LANES(NUM_LANES), .SYNC_STAGES(2),
    .DEBOUNCE_CYC(4), .SLOW_HALF(8), .FAST_HALF(2), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst(rst),
    .channel_up(channel_up), .lane_up(lane_up), .pll_lock(pll_lock),
    .calib_done(calib_done), .pb_raw(pb_raw),
    .led_link(led_link), .led_lanes(led_lanes), .led_pll(led_pll),
    .led_calib(led_calib), .drop_cnt(drop_cnt), .pb_pulse(pb_pulse)
`ifdef LSM_DROP_IRQ_EN
    , .drop_irq(drop_irq)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {
    K_LINK, K_LANES, K_PLL, K_CALIB, K_DROP, K_PB, K_PCNT, K_IRQ
  } kind_t;

  typedef struct {
    int    due;
    kind_t kind;
    int    idx;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  exp_t me;
  int   ma;

  always @(posedge clk) cyc++;

  function automatic int actual(kind_t k, int idx);
    case (k)
      K_LINK:  return int'(led_link[idx]);
      K_LANES: return int'(led_lanes[idx]);
      K_PLL:   return int'(led_pll[idx]);
      K_CALIB: return int'(led_calib);
      K_DROP:  return int'(drop_cnt[idx*DROP_W +: DROP_W]);
      K_PB:    return int'(pb_pulse);
      K_PCNT:  return pulses;
`ifdef LSM_DROP_IRQ_EN
      K_IRQ:   return int'(drop_irq);
`endif
      default: return -1;
    endcase
  endfunction

  // Monitor: pops every expectation that falls due this cycle
  always @(negedge clk) begin
    if (pb_pulse) pulses++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      me = sb.pop_front();
      ma = actual(me.kind, me.idx);
      checks++;
      if (me.due != cyc || ma != me.val) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (due %0d, cycle %0d)",
                 me.name, ma, me.val, me.due, cyc);
      end
    end
  end

  task automatic exp_at(int dly, kind_t k, int idx, int val, string name);
    exp_t e;
    int   pos;
    e   = '{cyc + dly, k, idx, val, name};
    pos = sb.size();
    while (pos > 0 && sb[pos-1].due > e.due) pos--;
    sb.insert(pos, e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blink_period(int ch, int span, int period, string name);
    logic prev;
    int   last;
    int   seen;
    prev = led_link[ch];
    last = -1;
    seen = 0;
    repeat (span) begin
      step(1);
      if (led_link[ch] !== prev) begin
        prev = led_link[ch];
        if (last >= 0) begin
          checks++;
          seen++;
          if (cyc - last != period) begin
            errors++;
            $display("FAIL %s: toggle interval %0d expected %0d",
                     name, cyc - last, period);
          end
        end
        last = cyc;
      end
    end
    checks++;
    if (seen < 2) begin
      errors++;
      $display("FAIL %s: toggle intervals seen %0d expected >= 2", name, seen);
    end
  endtask

  initial begin
    step(3);
    exp_at(0, K_LINK, 0, 0, "rst_link0");
    exp_at(0, K_LINK, 1, 0, "rst_link1");
    exp_at(0, K_DROP, 0, 0, "rst_drop0");
    exp_at(0, K_DROP, 1, 0, "rst_drop1");
    exp_at(0, K_PB, 0, 0, "rst_pb");
    exp_at(0, K_CALIB, 0, 0, "rst_calib");
    exp_at(0, K_PLL, 0, 0, "rst_pll0");
    exp_at(0, K_LANES, 1, 0, "rst_lanes1");
    step(1);
    rst = 1'b0;
    step(2);

    // PLL lock on ch0: TRAIN, slow blink
    pll_lock[0] = 1'b1;
    exp_at(3, K_PLL, 0, 0, "pll0_early");
    exp_at(4, K_PLL, 0, 1, "pll0_on");
    exp_at(4, K_PLL, 1, 0, "pll1_off");
    step(6);
    blink_period(0, 40, 8, "slow_blink");

    // Link up on ch0
    channel_up[0] = 1'b1;
    exp_at(4, K_LINK, 0, 1, "up_link0");
    exp_at(7, K_LINK, 0, 1, "up_link0_hold");
    exp_at(12, K_LINK, 0, 1, "up_link0_solid");
    step(13);

    // First drop on ch0
    channel_up[0] = 1'b0;
    exp_at(3, K_DROP, 0, 0, "drop0_early");
    exp_at(4, K_DROP, 0, 1, "drop0_first");
    step(6);
    blink_period(0, 16, 2, "fast_blink");

    // Drops 2..20 on ch0, saturating at 15
    for (int k = 2; k <= 20; k++) begin
      channel_up[0] = 1'b1;
      step(5);
      channel_up[0] = 1'b0;
      if (k == 14) exp_at(5, K_DROP, 0, 14, "drop0_14");
      if (k == 16) exp_at(5, K_DROP, 0, 15, "drop0_sat16");
      if (k == 20) begin
        exp_at(5, K_DROP, 0, 15, "drop0_sat20");
        exp_at(5, K_DROP, 1, 0, "drop1_idle");
      end
      step(5);
    end

    // Bouncing press: one pulse 6 cycles after the last edge
    pb_raw = 1'b1;
    step(1);
    pb_raw = 1'b0;
    step(1);
    pb_raw = 1'b1;
    exp_at(5, K_PB, 0, 0, "pb_early");
    exp_at(6, K_PB, 0, 1, "pb_pulse");
    exp_at(7, K_PB, 0, 0, "pb_single");
    exp_at(7, K_DROP, 0, 15, "clr_early");
    exp_at(8, K_DROP, 0, 0, "clr_drop0");
    exp_at(8, K_DROP, 1, 0, "clr_drop1");
    exp_at(8, K_LINK, 0, 0, "lost_to_down");
`ifdef LSM_DROP_IRQ_EN
    exp_at(6, K_IRQ, 0, 1, "irq_set");
    exp_at(7, K_IRQ, 0, 0, "irq_clr");
`endif
    step(20);
    exp_at(0, K_PCNT, 0, 1, "pb_hold_once");
    pb_raw = 1'b0;
    step(12);
    exp_at(0, K_PCNT, 0, 1, "pb_release");
    step(1);

    // ch1: one drop, then a drop coinciding with pb_pulse
    channel_up[1] = 1'b1;
    step(6);
    channel_up[1] = 1'b0;
    exp_at(5, K_DROP, 1, 1, "drop1_first");
    step(6);
    channel_up[1] = 1'b1;
    step(6);
    pb_raw = 1'b1;
    step(4);
    channel_up[1] = 1'b0;
    exp_at(2, K_PB, 0, 1, "pb_pulse2");
    exp_at(4, K_DROP, 1, 1, "drop1_and_clr");
    exp_at(4, K_DROP, 0, 0, "drop0_clr2");
`ifdef LSM_DROP_IRQ_EN
    exp_at(3, K_IRQ, 0, 1, "irq_set_wins");
`endif
    step(12);
    exp_at(0, K_PCNT, 0, 2, "pb_count2");
    pb_raw = 1'b0;
    step(12);

    // Lanes of ch1
    lane_up[7:4] = 4'b0111;
    exp_at(4, K_LANES, 1, 0, "lanes1_partial");
    step(6);
    lane_up[7:4] = 4'b1111;
    exp_at(3, K_LANES, 1, 0, "lanes1_early");
    exp_at(4, K_LANES, 1, 1, "lanes1_all");
    exp_at(4, K_LANES, 0, 0, "lanes0_off");
    step(6);

    // Calibration
    calib_done = 1'b1;
    exp_at(2, K_CALIB, 0, 0, "calib_early");
    exp_at(3, K_CALIB, 0, 1, "calib_on");
    step(5);

    // Reset with ch0 UP
    channel_up[0] = 1'b1;
    step(6);
    exp_at(0, K_LINK, 0, 1, "pre_rst_link0");
    exp_at(0, K_DROP, 1, 1, "pre_rst_drop1");
    step(1);
    rst = 1'b1;
    exp_at(1, K_LINK, 0, 0, "mid_rst_link0");
    exp_at(1, K_PLL, 0, 0, "mid_rst_pll0");
    exp_at(1, K_LANES, 1, 0, "mid_rst_lanes1");
    exp_at(1, K_CALIB, 0, 0, "mid_rst_calib");
    exp_at(1, K_DROP, 1, 0, "mid_rst_drop1");
`ifdef LSM_DROP_IRQ_EN
    exp_at(1, K_IRQ, 0, 0, "mid_rst_irq");
`endif
    step(3);
    rst = 1'b0;
    step(3);

    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
